// File: rtl/uart_out_interface.sv
// Byte buffer between the SoPU and a UART transmitter using an rts/rtr handshake.
// Define UART_OUT_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register buffers one byte.
module uart_out_interface #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write_enable,
    input  logic [7:0]                    byte_in,
    output logic                          write_ready,
    input  logic                          uart_to_sop_rtr,
    output logic                          sop_to_uart_rts,
    output logic [7:0]                    uart_byte_out,
    output logic                          byte_sent,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t     state;
    logic       push;
    logic       pop;
    logic [7:0] head_byte;

    assign push = write_enable && write_ready;
    assign pop  = (state == IDLE) && (fifo_count != '0);

`ifdef UART_OUT_FIFO_EN
    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign write_ready = (fifo_count < DEPTH_C);
    assign head_byte   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= byte_in;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
`else
    logic [7:0] hold_reg;

    assign write_ready = (fifo_count == '0);
    assign head_byte   = hold_reg;

    always_ff @(posedge clk) begin
        if (push) hold_reg <= byte_in;
    end

    // push needs an empty register and pop a full one, so they never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_count <= '0;
        end else if (push) begin
            fifo_count <= CW'(1);
        end else if (pop) begin
            fifo_count <= '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (write_enable && !write_ready) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            sop_to_uart_rts <= 1'b0;
            byte_sent       <= 1'b0;
            uart_byte_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        uart_byte_out   <= head_byte;
                        sop_to_uart_rts <= 1'b1;
                        state           <= SEND;
                    end
                end
                SEND: begin
                    if (uart_to_sop_rtr) begin
                        sop_to_uart_rts <= 1'b0;
                        byte_sent       <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    byte_sent <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    sop_to_uart_rts <= 1'b0;
                    byte_sent       <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_out_interface.sv
// Directed self-checking bench for uart_out_interface; FIFO scenarios run only when UART_OUT_FIFO_EN is defined.
module tb_uart_out_interface;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_enable = 1'b0;
    logic [7:0] byte_in = '0;
    logic       write_ready;
    logic       uart_to_sop_rtr = 1'b0;
    logic       sop_to_uart_rts;
    logic [7:0] uart_byte_out;
    logic       byte_sent;
    logic [2:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] sent_q[$];
    int         sent_cyc[$];

    uart_out_interface #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .write_enable(write_enable), .byte_in(byte_in),
        .write_ready(write_ready), .uart_to_sop_rtr(uart_to_sop_rtr),
        .sop_to_uart_rts(sop_to_uart_rts), .uart_byte_out(uart_byte_out),
        .byte_sent(byte_sent), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_sent === 1'b1) begin
            sent_q.push_back(uart_byte_out);
            sent_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; write_enable = 1'b0; uart_to_sop_rtr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        write_enable = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (sop_to_uart_rts !== 1'b0) begin bad++; $display("FAIL rst_rts: got %b want 0", sop_to_uart_rts); end
        total++; if (byte_sent !== 1'b0) begin bad++; $display("FAIL rst_sent: got %b want 0", byte_sent); end
        total++; if (uart_byte_out !== 8'h00) begin bad++; $display("FAIL rst_byte: got %h want 00", uart_byte_out); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        total++; if (write_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", write_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (write_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", write_ready); end
        total++; if (sop_to_uart_rts !== 1'b0) begin bad++; $display("FAIL post_rst_rts: got %b want 0", sop_to_uart_rts); end
    endtask

    task automatic test_single();
        int base;
        do_reset();
        uart_to_sop_rtr = 1'b1;
        base = sent_q.size();
        @(negedge clk); write_enable = 1'b1; byte_in = 8'hA5;
        @(negedge clk); write_enable = 1'b0;
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
        total++; if (sop_to_uart_rts !== 1'b0) begin bad++; $display("FAIL single_rts0: got %b want 0", sop_to_uart_rts); end
        @(negedge clk);
        total++; if (sop_to_uart_rts !== 1'b1) begin bad++; $display("FAIL single_rts1: got %b want 1", sop_to_uart_rts); end
        total++; if (uart_byte_out !== 8'hA5) begin bad++; $display("FAIL single_byte: got %h want a5", uart_byte_out); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_count0: got %0d want 0", fifo_count); end
        @(negedge clk);
        total++; if (byte_sent !== 1'b1) begin bad++; $display("FAIL single_pulse: got %b want 1", byte_sent); end
        total++; if (sop_to_uart_rts !== 1'b0) begin bad++; $display("FAIL single_rts_drop: got %b want 0", sop_to_uart_rts); end
        @(negedge clk);
        total++; if (byte_sent !== 1'b0) begin bad++; $display("FAIL single_pulse_end: got %b want 0", byte_sent); end
        repeat (6) @(negedge clk);
        total++; if (sent_q.size() - base !== 1) begin bad++; $display("FAIL single_npulses: got %0d want 1", sent_q.size() - base); end
        else begin
            total++; if (sent_q[base] !== 8'hA5) begin bad++; $display("FAIL single_sent_byte: got %h want a5", sent_q[base]); end
        end
        total++; if (uart_byte_out !== 8'hA5) begin bad++; $display("FAIL single_retain: got %h want a5", uart_byte_out); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_final_count: got %0d want 0", fifo_count); end
    endtask

`ifdef UART_OUT_FIFO_EN
    task automatic test_overflow();
        int base;
        int waited;
        logic [7:0] exp;
        do_reset();
        base = sent_q.size();
        // First byte is popped into the output register, so five writes fill four entries.
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); write_enable = 1'b1; byte_in = 8'(i);
        end
        @(negedge clk);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_full_count: got %0d want 4", fifo_count); end
        total++; if (write_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready: got %b want 0", write_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
        total++; if (uart_byte_out !== 8'h01) begin bad++; $display("FAIL ovf_head: got %h want 01", uart_byte_out); end
        byte_in = 8'h06;
        @(negedge clk); write_enable = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count_kept: got %0d want 4", fifo_count); end
        uart_to_sop_rtr = 1'b1;
        waited = 0;
        while (sent_q.size() < base + 5 && waited < 60) begin @(negedge clk); waited++; end
        total++; if (waited >= 60) begin bad++; $display("FAIL ovf_drain_timeout: got %0d pulses want 5", sent_q.size() - base); end
        repeat (8) @(negedge clk);
        total++; if (sent_q.size() - base !== 5) begin bad++; $display("FAIL ovf_npulses: got %0d want 5", sent_q.size() - base); end
        for (int i = 0; i < 5 && base + i < sent_q.size(); i++) begin
            exp = 8'(i + 1);
            total++; if (sent_q[base + i] !== exp) begin bad++; $display("FAIL ovf_order%0d: got %h want %h", i, sent_q[base + i], exp); end
            if (i > 0) begin
                total++; if (sent_cyc[base + i] - sent_cyc[base + i - 1] < 3) begin bad++; $display("FAIL ovf_gap%0d: got %0d want >=3", i, sent_cyc[base + i] - sent_cyc[base + i - 1]); end
            end
        end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL ovf_empty: got %0d want 0", fifo_count); end
    endtask

    task automatic test_simul_pop();
        do_reset();
        @(negedge clk); write_enable = 1'b1; byte_in = 8'h10;
        @(negedge clk); byte_in = 8'h20;
        @(negedge clk); byte_in = 8'h30;
        @(negedge clk); write_enable = 1'b0;
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL sim_setup_count: got %0d want 2", fifo_count); end
        total++; if (uart_byte_out !== 8'h10) begin bad++; $display("FAIL sim_setup_byte: got %h want 10", uart_byte_out); end
        uart_to_sop_rtr = 1'b1;
        @(negedge clk); uart_to_sop_rtr = 1'b0;
        total++; if (byte_sent !== 1'b1) begin bad++; $display("FAIL sim_done_pulse: got %b want 1", byte_sent); end
        @(negedge clk);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL sim_idle_count: got %0d want 2", fifo_count); end
        total++; if (sop_to_uart_rts !== 1'b0) begin bad++; $display("FAIL sim_idle_rts: got %b want 0", sop_to_uart_rts); end
        write_enable = 1'b1; byte_in = 8'h40;
        @(negedge clk); write_enable = 1'b0;
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL sim_count: got %0d want 2", fifo_count); end
        total++; if (uart_byte_out !== 8'h20) begin bad++; $display("FAIL sim_byte: got %h want 20", uart_byte_out); end
        total++; if (sop_to_uart_rts !== 1'b1) begin bad++; $display("FAIL sim_rts: got %b want 1", sop_to_uart_rts); end
    endtask
`else
    task automatic test_holding();
        int base;
        int waited;
        do_reset();
        base = sent_q.size();
        @(negedge clk); write_enable = 1'b1; byte_in = 8'h11;
        @(negedge clk); byte_in = 8'h22;
        total++; if (write_ready !== 1'b0) begin bad++; $display("FAIL hold_ready: got %b want 0", write_ready); end
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL hold_count1: got %0d want 1", fifo_count); end
        @(negedge clk); write_enable = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL hold_ovf: got %b want 1", overflow); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL hold_count0: got %0d want 0", fifo_count); end
        total++; if (uart_byte_out !== 8'h11) begin bad++; $display("FAIL hold_byte: got %h want 11", uart_byte_out); end
        repeat (3) @(negedge clk);
        total++; if (sop_to_uart_rts !== 1'b1) begin bad++; $display("FAIL hold_rts_wait: got %b want 1", sop_to_uart_rts); end
        total++; if (uart_byte_out !== 8'h11) begin bad++; $display("FAIL hold_byte_stable: got %h want 11", uart_byte_out); end
        uart_to_sop_rtr = 1'b1;
        waited = 0;
        while (sent_q.size() < base + 1 && waited < 20) begin @(negedge clk); waited++; end
        total++; if (waited >= 20) begin bad++; $display("FAIL hold_timeout: got %0d pulses want 1", sent_q.size() - base); end
        repeat (8) @(negedge clk);
        total++; if (sent_q.size() - base !== 1) begin bad++; $display("FAIL hold_npulses: got %0d want 1", sent_q.size() - base); end
        else begin
            total++; if (sent_q[base] !== 8'h11) begin bad++; $display("FAIL hold_sent: got %h want 11", sent_q[base]); end
        end
    endtask
`endif

    task automatic test_reset_mid();
        int base;
        do_reset();
        base = sent_q.size();
        @(negedge clk); write_enable = 1'b1; byte_in = 8'h5A;
        @(negedge clk); byte_in = 8'h6B;
        @(negedge clk); write_enable = 1'b0;
        total++; if (sop_to_uart_rts !== 1'b1) begin bad++; $display("FAIL mid_rts_before: got %b want 1", sop_to_uart_rts); end
        #2 rst = 1'b1;
        #1;
        total++; if (sop_to_uart_rts !== 1'b0) begin bad++; $display("FAIL mid_rts_drop: got %b want 0", sop_to_uart_rts); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
        total++; if (uart_byte_out !== 8'h00) begin bad++; $display("FAIL mid_byte: got %h want 00", uart_byte_out); end
        total++; if (write_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", write_ready); end
        uart_to_sop_rtr = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (sent_q.size() !== base) begin bad++; $display("FAIL mid_no_pulse: got %0d want 0", sent_q.size() - base); end
        total++; if (sop_to_uart_rts !== 1'b0) begin bad++; $display("FAIL mid_rts_after: got %b want 0", sop_to_uart_rts); end
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef UART_OUT_FIFO_EN
        test_overflow();
        test_simul_pop();
`else
        test_holding();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
